// File: rtl/output_display_pkg.sv
// output_display_pkg -- shared types and constants for the output display.
//   state_e     : conversion FSM states (IDLE, CONV)
//   NUM_DIGITS  : number of multiplexed digits (AN width)
//   NUM_ITER    : double-dabble iterations per 8-bit conversion
//   SEG_*       : active-low segment patterns, bit 0 = a ... bit 6 = g
//   seg_decode  : BCD digit -> segment pattern (non-decimal codes show blank)
package output_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_ITER   = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential 8-bit binary to 3-digit BCD converter
// (shift-and-add-3, one iteration per clock, 8 iterations).
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, aborts any conversion
//   start   : accepted in IDLE, or on the final iteration to chain a new
//             conversion without a gap
//   bin_in  : value captured on an accepted start
//   busy    : high while in CONV
//   done    : high during the cycle whose edge completes iteration 8
//   bcd_out : {hundreds, tens, ones}; valid while done is high
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | waiting for start
//   CONV  | one double-dabble iteration per clock, 8 total
module bin2bcd_seq
  import output_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);

  state_e      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic [19:0] step;
  logic        last_iter;

  // One iteration: add 3 to every BCD digit >= 5, then shift the whole
  // {bcd, bin} register left by one.
  always_comb begin
    step = {bcd_q, bin_q};
    for (int i = 0; i < 3; i++) begin
      if (step[8+4*i +: 4] >= 4'd5) begin
        step[8+4*i +: 4] = step[8+4*i +: 4] + 4'd3;
      end
    end
    step = step << 1;
  end

  assign last_iter = (state_q == CONV) && (iter_q == 3'(NUM_ITER - 1));
  assign busy      = (state_q == CONV);
  assign done      = last_iter;
  // The result of the final iteration is presented combinationally so the
  // consumer can latch it on the same edge that ends the conversion.
  assign bcd_out   = step[19:8];

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    if (state_q == CONV) begin
      bin_d  = step[7:0];
      bcd_d  = step[19:8];
      iter_d = iter_q + 3'd1;
      if (last_iter) begin
        state_d = IDLE;
      end
    end
    if (start && ((state_q == IDLE) || last_iter)) begin
      state_d = CONV;
      bin_d   = bin_in;
      bcd_d   = '0;
      iter_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: rtl/output_display.sv
// output_display -- shows the upstream output register on a 4-digit
// multiplexed 7-segment display.
//   CLK      : clock, rising edge
//   RESET    : synchronous active-high reset
//   OUT_VAL  : value held by the upstream output register
//   OUT_LOAD : one-cycle strobe, OUT_VAL has just been written
//   SEG      : active-low segments, SEG[0]=a .. SEG[6]=g (registered)
//   AN       : active-low digit enables, AN[0]=ones, AN[3]=sign (registered)
//   BUSY     : high while a binary-to-BCD conversion is running
// Parameter SCAN_DIV (2..65535): clocks each digit stays lit.
// Macro OUTPUT_DISPLAY_SIGNED_EN: treat the value as two's complement and
// show a minus sign on digit 3; otherwise unsigned with digit 3 blank.
module output_display
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            OUT_VAL,
  input  logic                  OUT_LOAD,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  BUSY
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic        conv_start;
  logic [7:0]  conv_val;
  logic [7:0]  conv_in;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_bcd;
  logic        sign_nxt;

  logic [7:0]            pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [11:0]           disp_q, disp_d;
  logic [15:0]           presc_q, presc_d;
  logic [1:0]            idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Load arbitration. A strobe during a conversion parks in the pending
  // register (latest wins). On the finishing edge the conversion chains
  // straight into the pending value, or into a strobe arriving on that
  // very edge, which is the newest value of all.
  always_comb begin
    conv_start = 1'b0;
    conv_val   = OUT_VAL;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (!conv_busy) begin
      conv_start = OUT_LOAD;
    end else if (conv_done) begin
      conv_start = OUT_LOAD || pend_vld_q;
      conv_val   = OUT_LOAD ? OUT_VAL : pend_q;
      pend_vld_d = 1'b0;
    end else if (OUT_LOAD) begin
      pend_d     = OUT_VAL;
      pend_vld_d = 1'b1;
    end
  end

`ifdef OUTPUT_DISPLAY_SIGNED_EN
  logic neg_conv_q, neg_conv_d;
  logic disp_neg_q, disp_neg_d;

  // -128 negates to 8'h80, which is 128 when read as unsigned magnitude.
  assign conv_in = conv_val[7] ? (~conv_val + 8'd1) : conv_val;

  always_comb begin
    neg_conv_d = conv_start ? conv_val[7] : neg_conv_q;
    disp_neg_d = conv_done ? neg_conv_q : disp_neg_q;
  end

  assign sign_nxt = disp_neg_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      neg_conv_q <= 1'b0;
      disp_neg_q <= 1'b0;
    end else begin
      neg_conv_q <= neg_conv_d;
      disp_neg_q <= disp_neg_d;
    end
  end
`else
  assign conv_in  = conv_val;
  assign sign_nxt = 1'b0;
`endif

  bin2bcd_seq u_bin2bcd (
    .clk     (CLK),
    .reset   (RESET),
    .start   (conv_start),
    .bin_in  (conv_in),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // Displayed digits change only when a full conversion completes.
  assign disp_d = conv_done ? conv_bcd : disp_q;

  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // SEG/AN are decoded from next-state values so both registers move on
  // the same edge as the digit index and any display update.
  always_comb begin
    case (idx_d)
      2'd0: seg_d = seg_decode(disp_d[3:0]);
      2'd1: seg_d = (disp_d[11:4] == 8'd0) ? SEG_BLANK : seg_decode(disp_d[7:4]);
      2'd2: seg_d = (disp_d[11:8] == 4'd0) ? SEG_BLANK : seg_decode(disp_d[11:8]);
      default: seg_d = sign_nxt ? SEG_MINUS : SEG_BLANK;
    endcase
    an_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_0;
      an_q       <= 4'b1110;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign BUSY = conv_busy;

endmodule

// File: tb/tb_output_display.sv
// tb_output_display -- directed bench for output_display with SCAN_DIV=4.
// Expected values for digit 3 and negative inputs follow the build macro
// OUTPUT_DISPLAY_SIGNED_EN.
module tb_output_display;

  localparam int SCAN_DIV = 4;
`ifdef OUTPUT_DISPLAY_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  localparam logic [6:0] B = 7'b1111111;
  localparam logic [6:0] M = 7'b0111111;
  logic [6:0] seg_tab [0:9];

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] OUT_VAL;
  logic       OUT_LOAD;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .OUT_VAL  (OUT_VAL),
    .OUT_LOAD (OUT_LOAD),
    .SEG      (SEG),
    .AN       (AN),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    OUT_VAL  = v;
    OUT_LOAD = 1'b1;
    tick();
    OUT_LOAD = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_for_an(input logic [3:0] exp);
    int n = 0;
    while (AN !== exp && n < 40) begin
      tick();
      n++;
    end
    check("sync_an", AN, exp);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] d [0:3];
    for (int k = 0; k < 4; k++) d[k] = 7'h55;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      case (AN)
        4'b1110: d[0] = SEG;
        4'b1101: d[1] = SEG;
        4'b1011: d[2] = SEG;
        4'b0111: d[3] = SEG;
        default: ;
      endcase
      tick();
    end
    check({tag, "_d3"}, d[3], e3);
    check({tag, "_d2"}, d[2], e2);
    check({tag, "_d1"}, d[1], e1);
    check({tag, "_d0"}, d[0], e0);
  endtask

  initial begin
    int n;
    bit saw34;
    logic [3:0] exp_an;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    RESET = 1'b1; OUT_LOAD = 1'b0; OUT_VAL = 8'd0;
    tick();
    tick();
    RESET = 1'b0;

    // Idle scan right after reset: each digit lit for 4 samples.
    check("rst_busy", BUSY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_an = ~(4'b0001 << (i / 4));
      check("scan_an", AN, exp_an);
      check("scan_seg", SEG, (i < 4) ? seg_tab[0] : B);
      tick();
    end

    load(8'hAA);
    check("aa_busy_now", BUSY, 1'b1);
    run_busy(n);
    check("aa_busy_len", n, 8);
    check_display("aa", SIGNED_BUILD ? M : B, SIGNED_BUILD ? B : seg_tab[1],
                  SIGNED_BUILD ? seg_tab[8] : seg_tab[7], SIGNED_BUILD ? seg_tab[6] : seg_tab[0]);

    load(8'd5);
    run_busy(n);
    check("v5_busy_len", n, 8);
    check_display("v5", B, B, B, seg_tab[5]);

    load(8'd0);
    run_busy(n);
    check_display("v0", B, B, B, seg_tab[0]);

    load(8'hFF);
    run_busy(n);
    check_display("vff", SIGNED_BUILD ? M : B, SIGNED_BUILD ? B : seg_tab[2],
                  SIGNED_BUILD ? B : seg_tab[5], SIGNED_BUILD ? seg_tab[1] : seg_tab[5]);

    load(8'h80);
    run_busy(n);
    check_display("v80", SIGNED_BUILD ? M : B, seg_tab[1], seg_tab[2], seg_tab[8]);

    // Chained conversion: align the scan so busy cycles 9..12 show the ones
    // digit and 13..16 the tens digit of the intermediate value 12.
    wait_for_an(4'b1110);
    wait_for_an(4'b1101);
    tick(); tick(); tick();
    load(8'd12);
    n = 0;
    saw34 = 1'b0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      if ((AN == 4'b1110 && SEG == seg_tab[4]) || (AN == 4'b1101 && SEG == seg_tab[3])) saw34 = 1'b1;
      if (n == 10) check("chain_ones12", SEG, seg_tab[2]);
      if (n == 14) check("chain_tens12", SEG, seg_tab[1]);
      OUT_LOAD = (n == 3 || n == 5);
      OUT_VAL  = (n == 3) ? 8'd34 : 8'd56;
      tick();
    end
    OUT_LOAD = 1'b0;
    check("chain_busy_len", n, 16);
    check("chain_never34", saw34, 1'b0);
    check_display("chain56", B, B, seg_tab[5], seg_tab[6]);

    // Reset mid-conversion, with a simultaneous strobe that must be ignored.
    load(8'd200);
    tick(); tick(); tick();
    check("abort_busy_before", BUSY, 1'b1);
    RESET = 1'b1; OUT_LOAD = 1'b1; OUT_VAL = 8'd77;
    tick();
    RESET = 1'b0; OUT_LOAD = 1'b0;
    check("abort_busy", BUSY, 1'b0);
    check("abort_an", AN, 4'b1110);
    check("abort_seg", SEG, seg_tab[0]);
    tick();
    check("abort_busy_after", BUSY, 1'b0);
    check_display("abort", B, B, B, seg_tab[0]);

    load(8'd99);
    run_busy(n);
    check("v99_busy_len", n, 8);
    check_display("v99", B, B, seg_tab[9], seg_tab[9]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, CLK cycles each digit stays lit (legal range 2..65535).
REQ-002 SHALL have port CLK  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL have port OUT_VAL  input  8  value held by the upstream output register.
REQ-005 SHALL have port OUT_LOAD  input  1  one-cycle strobe: the output register has just written OUT_VAL.
REQ-006 SHALL have port SEG  output  7  segments, active-low, SEG[0]=a through SEG[6]=g.
REQ-007 SHALL have port AN  output  4  digit enables, active-low, AN[0]=ones digit, AN[3]=leftmost (sign) digit.
REQ-008 SHALL have port BUSY  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 SHALL have two states: IDLE and CONV.
REQ-010 In IDLE, OUT_LOAD high at an edge SHALL capture OUT_VAL, clear the iteration counter and enter CONV.
REQ-011 CONV SHALL run one shift-and-add-3 (double-dabble) iteration per cycle, producing 3 BCD digits (hundreds, tens, ones) after exactly 8 iterations.
REQ-012 On the 8th iteration edge, the block SHALL atomically update the displayed digit registers and return to IDLE; BUSY = (state==CONV), high for exactly 8 cycles per conversion.
REQ-013 OUT_LOAD during CONV SHALL store OUT_VAL in a one-deep pending register; later strobes overwrite it (latest wins).
REQ-014 If pending is valid at the finishing edge, the block SHALL load the pending value, clear pending and stay in CONV (BUSY stays high, no gap).
REQ-015 The displayed value SHALL never show a partial conversion.
REQ-016 A prescaler SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-017 AN SHALL have exactly one bit low at all times, namely the bit of the current digit index.
REQ-018 Leading-zero blanking: hundreds digit SHALL be blank when 0; tens digit SHALL be blank when both hundreds and tens are 0; the ones digit is never blank.
REQ-019 Segment codes: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000, blank=7'b1111111, minus=7'b0111111.
REQ-020 SEG and AN SHALL be registered, changing together on the same edge.

Reset
REQ-021 RESET SHALL force: state=IDLE, BUSY=0, pending cleared, displayed value=0, prescaler=0, digit index=0, AN=4'b1110, SEG=7'b1000000.
REQ-022 RESET SHALL take priority over OUT_LOAD and abort any conversion in progress; the aborted value SHALL be discarded.

Configuration
REQ-023 With macro OUTPUT_DISPLAY_SIGNED_EN defined, the captured value SHALL be treated as two's complement: the magnitude is converted, and digit 3 shows minus when the value is negative, blank otherwise; -128 SHALL display as -128.
REQ-024 Without OUTPUT_DISPLAY_SIGNED_EN, the value SHALL be unsigned 0..255 and digit 3 SHALL always be blank.

Structure
REQ-025 Package output_display_pkg SHALL hold the state enum, the segment constants of REQ-019 and the digit count (4).
REQ-026 The conversion SHALL live in sub-module bin2bcd_seq (start, 8-bit in, busy, done, 12-bit BCD out); output_display owns the pending register, blanking and scan logic.

Verification (SCAN_DIV=4)
REQ-027 Reset, then no load -> AN cycles 1110,1101,1011,0111 every 4 cycles; SEG=1000000 on digit 0 and 1111111 on the others.
REQ-028 OUT_LOAD with OUT_VAL=8'hAA (170), unsigned build -> BUSY high exactly 8 cycles; then digits 1,7,0 = 1111001,1111000,1000000; digit 3 blank.
REQ-029 OUT_VAL=8'd5 -> hundreds and tens blank, ones=0010010; then OUT_VAL=8'd0 -> ones=1000000, all others blank.
REQ-030 Load 8'd12, then strobe 8'd34 at busy cycle 3 and 8'd56 at busy cycle 5 -> display goes 12 -> 56 (34 never shown); BUSY stays high 16 consecutive cycles.
REQ-031 Signed build, OUT_VAL=8'hAA -> display -86 (digit 3 minus, digit 2 blank, digits 1 and 0 = 8 and 6); OUT_VAL=8'h80 -> -128.
REQ-032 RESET asserted at busy cycle 4 -> next edge BUSY=0 and display shows 0; a following load of 8'd99 -> 99 after 8 cycles.
